// File: rtl/count_ctrl_fsm.sv
// Sequencing controller for the 4-digit up/down counter: switch decode, count-enable prescaler, error latch.
// Optional build macro COUNT_CTRL_ERR_CLEAR_EN adds err_clr to leave the error states without reset.
module count_ctrl_fsm #(
  parameter int unsigned TICK_DIV = 4,
  parameter logic [3:0]  ERR_DIG3 = 4'hE,
  parameter logic [3:0]  ERR_DIG2 = 4'hC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic       m,
  input  logic       l,
`ifdef COUNT_CTRL_ERR_CLEAR_EN
  input  logic       err_clr,
`endif
  output logic       rstn,
  output logic       mode,
  output logic       load,
  output logic       strt,
  output logic       run,
  output logic       is_err,
  output logic [3:0] err0,
  output logic [3:0] err1,
  output logic [3:0] err2,
  output logic [3:0] err3
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    SAVE = 3'd0,
    LOAD = 3'd1,
    UP   = 3'd2,
    DOWN = 3'd3,
    ER1  = 3'd4,
    ER2  = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic          l_q;
  logic          l_rise;
  logic [PW-1:0] pcnt, pcnt_nxt;
  logic          cnt_nxt;

  assign l_rise = l & ~l_q;

  // Next-state decode; while counting, !s beats a mode change, which beats l_rise.
  always_comb begin
    state_nxt = state;
    unique case (state)
      SAVE: begin
        if (l_rise)  state_nxt = LOAD;
        else if (!s) state_nxt = SAVE;
        else if (m)  state_nxt = DOWN;
        else         state_nxt = UP;
      end
      LOAD: begin
        if (!s)     state_nxt = SAVE;
        else if (m) state_nxt = DOWN;
        else        state_nxt = UP;
      end
      UP: begin
        if (!s)          state_nxt = SAVE;
        else if (m)      state_nxt = ER1;
        else if (l_rise) state_nxt = ER2;
      end
      DOWN: begin
        if (!s)          state_nxt = SAVE;
        else if (!m)     state_nxt = ER1;
        else if (l_rise) state_nxt = ER2;
      end
      ER1, ER2: begin
`ifdef COUNT_CTRL_ERR_CLEAR_EN
        if (err_clr) state_nxt = SAVE;
`endif
      end
      default: state_nxt = SAVE;
    endcase
  end

  // Prescaler restarts on entry to UP/DOWN; strt marks the wrap cycle.
  always_comb begin
    cnt_nxt  = (state_nxt == UP) || (state_nxt == DOWN);
    pcnt_nxt = '0;
    if (cnt_nxt && (state == UP || state == DOWN)) begin
      pcnt_nxt = (pcnt == PCNT_LAST) ? '0 : pcnt + PW'(1);
    end
  end

  // Outputs are registered from the next state so they follow the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= SAVE;
      l_q    <= 1'b0;
      pcnt   <= '0;
      rstn   <= 1'b0;
      mode   <= 1'b0;
      load   <= 1'b0;
      strt   <= 1'b0;
      run    <= 1'b0;
      is_err <= 1'b0;
      err0   <= 4'h0;
      err1   <= 4'h0;
      err2   <= 4'h0;
      err3   <= 4'h0;
    end else begin
      state  <= state_nxt;
      l_q    <= l;
      pcnt   <= pcnt_nxt;
      rstn   <= (state_nxt == ER1) || (state_nxt == ER2);
      mode   <= (state_nxt == DOWN);
      load   <= (state_nxt == LOAD);
      strt   <= cnt_nxt && (pcnt_nxt == PCNT_LAST);
      run    <= cnt_nxt;
      is_err <= (state_nxt == ER1) || (state_nxt == ER2);
      err0   <= (state_nxt == ER1) ? 4'h1 : (state_nxt == ER2) ? 4'h2 : 4'h0;
      err1   <= 4'h0;
      err2   <= (state_nxt == ER1 || state_nxt == ER2) ? ERR_DIG2 : 4'h0;
      err3   <= (state_nxt == ER1 || state_nxt == ER2) ? ERR_DIG3 : 4'h0;
    end
  end

endmodule
